// File: rtl/approx_mult_error_monitor_pkg.sv
// ----------------------------------------------------------------------------
// approx_mult_error_monitor_pkg
// Shared definitions for the approximate-multiplier error monitor:
//   - operand / product widths of the 8x8 multiplier under test
//   - pipeline depth (also the number of DRAIN cycles)
//   - campaign FSM state encoding
//   - absolute-difference helper used for the error distance
// ----------------------------------------------------------------------------
package approx_mult_error_monitor_pkg;

  localparam int OP_W       = 8;
  localparam int PROD_W     = 16;
  localparam int PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // |x - y| without wrap: always subtract the smaller from the larger.
  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y);
    logic [PROD_W-1:0] d;
    if (x >= y) begin
      d = x - y;
    end else begin
      d = y - x;
    end
    return d;
  endfunction

endpackage

// File: rtl/approx_ed_calc.sv
// ----------------------------------------------------------------------------
// approx_ed_calc
// Purely combinational error-distance calculator for one (a, b, approx) triple.
// Ports:
//   a, b    in   8  unsigned operands
//   approx  in  16  approximate product for (a, b)
//   exact   out 16  exact product a*b
//   ed      out 16  |exact - approx|
//   is_err  out  1  ed != 0
// ----------------------------------------------------------------------------
module approx_ed_calc
  import approx_mult_error_monitor_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx,
  output logic [PROD_W-1:0] exact,
  output logic [PROD_W-1:0] ed,
  output logic              is_err
);

  // Exact product, distance to the approximate result and the error flag.
  always_comb begin
    exact  = PROD_W'(a) * PROD_W'(b);
    ed     = abs_diff(exact, approx);
    is_err = (ed != {PROD_W{1'b0}});
  end

endmodule

// File: rtl/approx_mult_error_monitor.sv
// ----------------------------------------------------------------------------
// approx_mult_error_monitor
// Samples (a, b, approx_prod) triples from the approximate multiplier under a
// valid/ready handshake and accumulates error statistics over a campaign of
// N_SAMPLES accepted samples.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start               begin a campaign (honoured in IDLE / DONE only)
//   in_valid/in_ready   sample handshake
//   a, b, approx_prod   sample triple
//   busy                high in RUN and DRAIN
//   done                high in DONE until start or RST
//   sample_cnt, err_cnt samples accumulated / samples with non-zero ED
//   ed_sum              saturating sum of ED
//   ed_max, ed_max_a/b  peak ED and the operands that first produced it
// Pipeline: accept edge -> stage 1 (distance registered) -> stage 2 (carry)
// -> statistics, so a sample accepted at edge t is visible after edge t+2.
// ----------------------------------------------------------------------------
module approx_mult_error_monitor
  import approx_mult_error_monitor_pkg::*;
#(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int ACC_W     = 32
)(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  input  logic [PROD_W-1:0]  approx_prod,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   ed_sum,
  output logic [PROD_W-1:0]  ed_max,
  output logic [OP_W-1:0]    ed_max_a,
  output logic [OP_W-1:0]    ed_max_b
);

  // Sum is formed one bit wider than the wider of accumulator and ED so the
  // overflow can be detected before clamping.
  localparam int                SUM_W      = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [SUM_W-1:0]  ACC_MAX    = SUM_W'({ACC_W{1'b1}});
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N_SAMPLES - 1);
  localparam int                DR_W       = 2;
  localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(PIPE_DEPTH - 1);

  state_e             state_r;
  logic [CNT_W-1:0]   accepted_r;
  logic [DR_W-1:0]    drain_cnt_r;

  logic               accept_s;
  logic               clear_s;

  // The exact product is exposed by the calculator but the statistics only
  // consume the distance derived from it.
  logic [PROD_W-1:0]  exact_unused_s;
  logic [PROD_W-1:0]  ed_s;
  logic               is_err_s;

  logic               s1_valid_r;
  logic [OP_W-1:0]    s1_a_r;
  logic [OP_W-1:0]    s1_b_r;
  logic [PROD_W-1:0]  s1_ed_r;
  logic               s1_err_r;

  logic               s2_valid_r;
  logic [OP_W-1:0]    s2_a_r;
  logic [OP_W-1:0]    s2_b_r;
  logic [PROD_W-1:0]  s2_ed_r;
  logic               s2_err_r;

  logic [SUM_W-1:0]   sum_s;
  logic [ACC_W-1:0]   sum_next_s;

  // Handshake qualifiers: sample acceptance and campaign (re)start.
  always_comb begin
    accept_s = in_valid && in_ready;
    clear_s  = start && ((state_r == IDLE) || (state_r == DONE));
  end

  approx_ed_calc u_ed_calc (
    .a      (a),
    .b      (b),
    .approx (approx_prod),
    .exact  (exact_unused_s),
    .ed     (ed_s),
    .is_err (is_err_s)
  );

  // Campaign FSM with registered in_ready / busy / done.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      accepted_r  <= {CNT_W{1'b0}};
      drain_cnt_r <= {DR_W{1'b0}};
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r     <= RUN;
            accepted_r  <= {CNT_W{1'b0}};
            drain_cnt_r <= {DR_W{1'b0}};
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (accept_s) begin
            accepted_r <= accepted_r + CNT_W'(1);
            if (accepted_r == LAST_IDX) begin
              // Last sample of the campaign: stop accepting, flush pipeline.
              state_r     <= DRAIN;
              drain_cnt_r <= {DR_W{1'b0}};
              in_ready    <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + DR_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage sample pipeline; valid bits are dropped on reset and restart.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {OP_W{1'b0}};
      s1_b_r     <= {OP_W{1'b0}};
      s1_ed_r    <= {PROD_W{1'b0}};
      s1_err_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_a_r     <= {OP_W{1'b0}};
      s2_b_r     <= {OP_W{1'b0}};
      s2_ed_r    <= {PROD_W{1'b0}};
      s2_err_r   <= 1'b0;
    end else if (clear_s) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      s2_valid_r <= s1_valid_r;
      if (accept_s) begin
        s1_a_r   <= a;
        s1_b_r   <= b;
        s1_ed_r  <= ed_s;
        s1_err_r <= is_err_s;
      end
      if (s1_valid_r) begin
        s2_a_r   <= s1_a_r;
        s2_b_r   <= s1_b_r;
        s2_ed_r  <= s1_ed_r;
        s2_err_r <= s1_err_r;
      end
    end
  end

  // Saturating next value of the ED accumulator.
  always_comb begin
    sum_s = SUM_W'(ed_sum) + SUM_W'(s2_ed_r);
    if (sum_s > ACC_MAX) begin
      sum_next_s = {ACC_W{1'b1}};
    end else begin
      sum_next_s = sum_s[ACC_W-1:0];
    end
  end

  // Statistics accumulation from the stage-2 sample.
  always_ff @(posedge CLK) begin
    if (RST || clear_s) begin
      sample_cnt <= {CNT_W{1'b0}};
      err_cnt    <= {CNT_W{1'b0}};
      ed_sum     <= {ACC_W{1'b0}};
      ed_max     <= {PROD_W{1'b0}};
      ed_max_a   <= {OP_W{1'b0}};
      ed_max_b   <= {OP_W{1'b0}};
    end else if (s2_valid_r) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (s2_err_r) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      ed_sum <= sum_next_s;
      // Strictly greater: the first sample reaching a peak keeps it.
      if (s2_ed_r > ed_max) begin
        ed_max   <= s2_ed_r;
        ed_max_a <= s2_a_r;
        ed_max_b <= s2_b_r;
      end
    end
  end

endmodule
